// File: rtl/avg_channel_scheduler.sv
// Round-robin scheduler sharing one N-window running-average engine among NUM_CH sample streams.
// One sample per IDLE->CALC->HOLD pass; result valid one cycle after CALC and held until out_ready_i.
module avg_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int N         = 4,
  parameter int DATAWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             req_valid_i,
  input  logic [NUM_CH*DATAWIDTH-1:0]   req_data_i,
  output logic [NUM_CH-1:0]             req_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(NUM_CH)-1:0]     out_ch_o,
  output logic [DATAWIDTH-1:0]          out_avg_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam int M  = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_ch_q;
  logic [CW-1:0]        w_gnt;
  logic                 w_any;
  logic [DATAWIDTH-1:0] r_data_q;
  logic [DATAWIDTH-1:0] w_sum_new;
  logic [DATAWIDTH-1:0] r_hist [NUM_CH][N];
  logic [DATAWIDTH-1:0] r_sum  [NUM_CH];

  // Scan offsets from the far end down so the channel closest to r_rr_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(r_rr_ptr) + k) % NUM_CH]) begin
        w_any = 1'b1;
        w_gnt = CW'((int'(r_rr_ptr) + k) % NUM_CH);
      end
    end
  end

  assign w_sum_new = r_sum[r_ch_q] - r_hist[r_ch_q][N-1] + r_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = CALC;
      CALC:    w_next = HOLD;
      HOLD:    if (out_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (r_state == IDLE && w_any && !reset) req_ready_o[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_ch_q      <= '0;
      r_data_q    <= '0;
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      out_avg_o   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_sum[c] <= '0;
        for (int i = 0; i < N; i++) r_hist[c][i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ch_q   <= w_gnt;
            r_data_q <= req_data_i[int'(w_gnt)*DATAWIDTH +: DATAWIDTH];
          end
        end
        CALC: begin
          for (int i = N - 1; i > 0; i--) r_hist[r_ch_q][i] <= r_hist[r_ch_q][i-1];
          r_hist[r_ch_q][0] <= r_data_q;
          r_sum[r_ch_q]     <= w_sum_new;
          out_avg_o         <= w_sum_new >> M;
          out_ch_o          <= r_ch_q;
          out_valid_o       <= 1'b1;
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            r_rr_ptr    <= (int'(r_ch_q) == NUM_CH - 1) ? '0 : r_ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Scoreboard bench: a reference averager predicts each result at acceptance; checks happen on the falling edge.
module tb_avg_channel_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready_o;
  logic         out_valid_o;
  logic         out_ready = 1'b1;
  logic [1:0]   out_ch_o;
  logic [31:0]  out_avg_o;

  int n_vec = 0;
  int n_err = 0;

  avg_channel_scheduler #(.NUM_CH(4), .N(4), .DATAWIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .out_ch_o    (out_ch_o),
    .out_avg_o   (out_avg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_hist [4][4];
  logic [31:0] m_sum  [4];
  int          m_ptr;
  bit          m_busy;
  int          m_age;
  logic [33:0] exp_q[$];
  logic [33:0] log_q[$];

  always @(negedge clk) begin
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [31:0] d, s;
    logic [33:0] e;
    int          g, idx;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        m_sum[c] = '0;
        for (int i = 0; i < 4; i++) m_hist[c][i] = '0;
      end
      m_ptr = 0; m_busy = 0; m_age = 0;
      exp_q.delete();
    end else begin
      if (m_busy) m_age++;
      exp_ov  = m_busy && (m_age >= 2);
      exp_rdy = '0;
      g = 0;
      if (!m_busy) begin
        for (int k = 3; k >= 0; k--) begin
          idx = (m_ptr + k) % 4;
          if (req_valid[idx]) begin
            exp_rdy = 4'b0001 << idx;
            g = idx;
          end
        end
      end
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid_o), 64'(exp_ov));
      if (exp_ov) chk("result", 64'({out_ch_o, out_avg_o}), 64'(exp_q[0]));
      if (exp_ov && out_ready) begin
        log_q.push_back({out_ch_o, out_avg_o});
        e = exp_q.pop_front();
        m_ptr = (int'(e[33:32]) + 1) % 4;
        m_busy = 0;
      end else if (exp_rdy != 0) begin
        d = req_data[g*32 +: 32];
        s = m_sum[g] - m_hist[g][3] + d;
        for (int i = 3; i > 0; i--) m_hist[g][i] = m_hist[g][i-1];
        m_hist[g][0] = d;
        m_sum[g] = s;
        exp_q.push_back({2'(g), s >> 2});
        m_busy = 1;
        m_age = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 4'($urandom);
    req_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_avg", 64'(out_avg_o), 64'd0);
      chk("rst_ch", 64'(out_ch_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
    end
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready_o), 64'd0);
    chk("post_rst_valid", 64'(out_valid_o), 64'd0);
    log_q.delete();
  endtask

  // Raise the masked requests; each drops the cycle after its grant.
  task automatic drive(input logic [3:0] mask, input logic [31:0] d0, d1, d2, d3);
    logic [3:0] g;
    @(posedge clk); #1;
    req_data  = {d3, d2, d1, d0};
    req_valid = mask;
    for (int t = 0; t < 200 && req_valid != 0; t++) begin
      @(negedge clk);
      g = req_ready_o & req_valid;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
    end
    chk("drain", 64'(req_valid), 64'd0);
    req_valid = '0;
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 200 && log_q.size() < n; t++) @(negedge clk);
    #1;
    chk("result_count", 64'(log_q.size()), 64'(n));
  endtask

  task automatic wait_out_valid();
    for (int t = 0; t < 50 && !out_valid_o; t++) @(negedge clk);
    chk("wait_valid", 64'(out_valid_o), 64'd1);
  endtask

  task automatic exp_log(input string tag, input int i, input logic [1:0] ch, input logic [31:0] avg);
    chk(tag, 64'((i < log_q.size()) ? log_q[i] : 34'h3_DEAD_BEEF), 64'({ch, avg}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single channel with warm-up
    drive(4'b0001, 32'd4, 0, 0, 0);
    drive(4'b0001, 32'd8, 0, 0, 0);
    drive(4'b0001, 32'd12, 0, 0, 0);
    drive(4'b0001, 32'd16, 0, 0, 0);
    drive(4'b0001, 32'd20, 0, 0, 0);
    wait_results(5);
    exp_log("single0", 0, 2'd0, 32'd1);
    exp_log("single1", 1, 2'd0, 32'd3);
    exp_log("single2", 2, 2'd0, 32'd6);
    exp_log("single3", 3, 2'd0, 32'd10);
    exp_log("single4", 4, 2'd0, 32'd14);

    // Simultaneous requests, two rounds
    do_reset();
    drive(4'b1111, 32'd4, 32'd8, 32'd40, 32'd12);
    wait_results(4);
    exp_log("rr0", 0, 2'd0, 32'd1);
    exp_log("rr1", 1, 2'd1, 32'd2);
    exp_log("rr2", 2, 2'd2, 32'd10);
    exp_log("rr3", 3, 2'd3, 32'd3);
    drive(4'b1111, 32'd4, 32'd8, 32'd40, 32'd12);
    wait_results(8);
    exp_log("rr4", 4, 2'd0, 32'd2);
    exp_log("rr6", 6, 2'd2, 32'd20);

    // Backpressure in HOLD with a competing request waiting
    do_reset();
    out_ready = 1'b0;
    drive(4'b1000, 0, 0, 0, 32'd100);
    wait_out_valid();
    @(posedge clk); #1;
    req_data[31:0] = 32'd4;
    req_valid = 4'b0001;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid_o), 64'd1);
      chk("bp_avg", 64'(out_avg_o), 64'd25);
      chk("bp_ch", 64'(out_ch_o), 64'd3);
      chk("bp_ready", 64'(req_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_one_result", 64'(log_q.size()), 64'd1);
    drive(4'b0001, 32'd4, 0, 0, 0);
    wait_results(2);
    exp_log("bp_r0", 0, 2'd3, 32'd25);
    exp_log("bp_r1", 1, 2'd0, 32'd1);

    // Modular sum wrap-around
    do_reset();
    drive(4'b0010, 0, 32'hFFFF_FFFF, 0, 0);
    drive(4'b0010, 0, 32'd1, 0, 0);
    drive(4'b0001, 32'd8, 0, 0, 0);
    wait_results(3);
    exp_log("wrap0", 0, 2'd1, 32'h3FFF_FFFF);
    exp_log("wrap1", 1, 2'd1, 32'h0000_0000);
    exp_log("wrap_other", 2, 2'd0, 32'd2);

    // Reset while a ch2 result is held
    do_reset();
    drive(4'b0001, 32'd0, 0, 0, 0);
    wait_results(1);
    out_ready = 1'b0;
    drive(4'b0100, 0, 0, 32'd40, 0);
    wait_out_valid();
    #2 reset = 1'b1;
    #1 chk("async_drop", 64'(out_valid_o), 64'd0);
    do_reset();
    drive(4'b0101, 32'd4, 0, 32'd8, 0);
    wait_results(2);
    exp_log("mid_rst0", 0, 2'd0, 32'd1);
    exp_log("mid_rst1", 1, 2'd2, 32'd2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avg_channel_scheduler.md
# avg_channel_scheduler

Round-robin scheduler that shares one running-average engine among NUM_CH independent sample streams. Each channel keeps its own N-deep sample history and running sum. Per-channel results are identical to a dedicated N-window running averager. The block sits between multiple sensor/data producers and a single downstream consumer, and adds valid/ready handshakes on both sides.

## Interface
- NUM_CH, 4, number of requesting channels (≥2)
- N, 4, averaging window length per channel (power of two, ≥2)
- DATAWIDTH, 32, sample and result width
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid_i  input  NUM_CH  per-channel sample valid
- req_data_i  input  NUM_CH*DATAWIDTH  per-channel samples; channel c occupies bits [c*DATAWIDTH +: DATAWIDTH]
- req_ready_o  output  NUM_CH  one-hot (or zero) grant/accept
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- out_ch_o  output  $clog2(NUM_CH)  channel the result belongs to
- out_avg_o  output  DATAWIDTH  windowed average for out_ch_o

## Operation
- M = $clog2(N). Storage per channel: hist[c][0..N-1] and sum[c], each DATAWIDTH bits. rr_ptr is $clog2(NUM_CH) bits.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - If any req_valid_i bit is set, grant g is the first valid channel searching from rr_ptr upward, with wrap-around.
  - req_ready_o[g]=1 combinationally. All other bits are 0.
  - On the clock edge: latch ch_q=g and data_q=req_data_i[g], then go to CALC.
  - If no request is valid: req_ready_o=0 and the FSM stays in IDLE.
- CALC:
  - sum_new = sum[ch_q] - hist[ch_q][N-1] + data_q, computed modulo 2^DATAWIDTH with no saturation.
  - Shift hist[ch_q] so that [i] <= [i-1] and [0] <= data_q. Write sum[ch_q] <= sum_new.
  - Register out_avg_o <= sum_new >> M (logical shift), out_ch_o <= ch_q, out_valid_o <= 1.
  - Go to HOLD.
- HOLD:
  - out_valid_o stays 1. out_avg_o and out_ch_o stay stable.
  - When out_ready_i=1: out_valid_o <= 0, rr_ptr <= (ch_q+1) mod NUM_CH, go to IDLE.
- Channels not granted are untouched. A request must hold its valid and data until its ready is asserted.
- req_ready_o is 0 in CALC and HOLD. No samples are accepted while a result is pending.
- Warm-up: histories start at zero, so the first N-1 results of a channel include zeros. No special handling.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, all hist and sum entries = 0.
  - out_valid_o=0, out_avg_o=0, out_ch_o=0, req_ready_o=0 while reset is asserted.
- Latency: a sample accepted at edge t produces out_valid_o=1 after edge t+1 (visible in the cycle following CALC).
- Throughput: at most one sample per 3 cycles with out_ready_i held high.
- If out_ready_i is already 1 on entering HOLD, HOLD lasts exactly one cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losing channels wait. Fairness bound: a continuously valid channel is granted within NUM_CH grants.
- req_valid_i deasserting in CALC or HOLD has no effect.
- Reset mid-operation (any state):
  - Return to IDLE immediately and drop out_valid_o asynchronously.
  - The latched sample and pending result are discarded.
  - All histories and sums are cleared.
- Sum wrap-around is intentional. Because the add and subtract are modular, the sum stays exact relative to the stored samples.

## Test plan
All scenarios use NUM_CH=4, N=4, DATAWIDTH=32.
- Reset behaviour: assert reset with random inputs -> all outputs 0. Release reset with no requests -> req_ready_o=0, out_valid_o=0.
- Single channel: ch0 samples 4, 8, 12, 16 with out_ready_i=1 -> out_avg_o = 1, 3, 6, 10 and out_ch_o=0. A fifth sample 20 -> 14.
- Simultaneous requests: all channels valid after reset, data ch0=4, ch1=8, ch2=40, ch3=12 -> grant order 0, 1, 2, 3 and results 1, 2, 10, 3. The next round also starts at ch0.
- Backpressure: hold out_ready_i=0 for 5 cycles in HOLD -> out_valid_o=1, out_avg_o and out_ch_o stable, req_ready_o=0 throughout. Exactly one result is delivered when out_ready_i rises.
- Wrap-around: ch1 samples 0xFFFFFFFF then 1 -> results 0x3FFFFFFF then 0x00000000. Other channels are unaffected.
- Reset mid-operation: assert reset in HOLD for ch2 -> out_valid_o=0 immediately. After release, a ch2 sample of 8 -> 2 (history cleared), and the grant starts from ch0.
